// File: rtl/inst_fetch_port.sv
// Instruction-bus fetch front end: reads the word at the current PC, presents it at IF/ID and stalls the PC while a fetch is outstanding.
// Optional fetch timeout is compiled in with INST_FETCH_TIMEOUT_EN.
module inst_fetch_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_address,
    input  logic        pc_flush,
    input  logic        stall_hold,
    output logic        stall_request,
    output logic        bus_request,
    output logic [31:0] bus_address,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic        fetch_exception
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_bus_request;
    logic [31:0] r_bus_address;
    logic [31:0] r_instruction;
    logic        r_instruction_valid;
    logic        r_fetch_exception;

    logic        w_aligned;
    logic        w_xfer;

    assign w_aligned = (pc_address[1:0] == 2'b00);
    // A beat is only taken when downstream is not stalled; bus_ready is ignored otherwise.
    assign w_xfer    = r_bus_request & bus_ready & ~stall_hold;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_expired;

    assign w_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        stall_request = 1'b1;
        case (r_state)
            ST_IDLE:    stall_request = w_aligned & ~pc_flush;
            ST_REQUEST: stall_request = ~(bus_ready & ~stall_hold);
            ST_DISCARD: stall_request = 1'b1;
            default:    stall_request = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_bus_request       <= 1'b0;
            r_bus_address       <= 32'h0;
            r_instruction       <= 32'h0;
            r_instruction_valid <= 1'b0;
            r_fetch_exception   <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
            r_wait_cnt          <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_flush) begin
                        r_instruction_valid <= 1'b0;
                        r_fetch_exception   <= 1'b0;
                    end else if (!stall_hold) begin
                        if (!w_aligned) begin
                            r_instruction       <= NOP_WORD;
                            r_instruction_valid <= 1'b1;
                            r_fetch_exception   <= 1'b1;
                        end else begin
                            r_bus_address       <= pc_address;
                            r_bus_request       <= 1'b1;
                            r_instruction_valid <= 1'b0;
                            r_fetch_exception   <= 1'b0;
                            r_state             <= ST_REQUEST;
`ifdef INST_FETCH_TIMEOUT_EN
                            r_wait_cnt          <= '0;
`endif
                        end
                    end
                end

                ST_REQUEST: begin
                    if (w_xfer) begin
                        r_bus_request <= 1'b0;
                        r_state       <= ST_IDLE;
                        if (pc_flush) begin
                            r_instruction_valid <= 1'b0;
                            r_fetch_exception   <= 1'b0;
                        end else begin
                            r_instruction       <= bus_read_data;
                            r_instruction_valid <= 1'b1;
                            r_fetch_exception   <= 1'b0;
                        end
                    end else if (pc_flush) begin
                        // Request stays up: the responder must still see the beat accepted.
                        r_state             <= ST_DISCARD;
                        r_instruction_valid <= 1'b0;
                        r_fetch_exception   <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
                        r_wait_cnt          <= '0;
`endif
                    end
`ifdef INST_FETCH_TIMEOUT_EN
                    else if (w_expired) begin
                        r_bus_request       <= 1'b0;
                        r_state             <= ST_IDLE;
                        r_instruction       <= NOP_WORD;
                        r_instruction_valid <= 1'b1;
                        r_fetch_exception   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_DISCARD: begin
                    if (w_xfer) begin
                        r_bus_request <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
`ifdef INST_FETCH_TIMEOUT_EN
                    else if (w_expired) begin
                        r_bus_request <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_bus_request <= 1'b0;
                end
            endcase
        end
    end

    assign bus_request       = r_bus_request;
    assign bus_address       = r_bus_address;
    assign instruction       = r_instruction;
    assign instruction_valid = r_instruction_valid;
    assign fetch_exception   = r_fetch_exception;

endmodule

// File: tb/tb_inst_fetch_port.sv
// Randomized transaction-level bench for inst_fetch_port: the driver queues expected bus addresses and deliveries, a monitor pops and compares them.
module tb_inst_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef INST_FETCH_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int MAXW = 2;
    localparam int MAXS = 1;
`else
    localparam int TO   = 255;
    localparam int MAXW = 4;
    localparam int MAXS = 2;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] pc_address;
    logic        pc_flush;
    logic        stall_hold;
    logic        stall_request;
    logic        bus_request;
    logic [31:0] bus_address;
    logic        bus_ready;
    logic [31:0] bus_read_data;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        fetch_exception;

    inst_fetch_port #(
        .TIMEOUT_CYCLES(TO),
        .NOP_WORD      (NOP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_address       (pc_address),
        .pc_flush         (pc_flush),
        .stall_hold       (stall_hold),
        .stall_request    (stall_request),
        .bus_request      (bus_request),
        .bus_address      (bus_address),
        .bus_ready        (bus_ready),
        .bus_read_data    (bus_read_data),
        .instruction      (instruction),
        .instruction_valid(instruction_valid),
        .fetch_exception  (fetch_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic        exc;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic void check1(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endfunction

    task automatic drive(input logic [31:0] pc, input logic fl, input logic st,
                         input logic rdy, input logic [31:0] dat);
        @(negedge clock);
        pc_address    = pc;
        pc_flush      = fl;
        stall_hold    = st;
        bus_ready     = rdy;
        bus_read_data = dat;
        #1;
    endtask

    // mode 0: normal, mode 1: flush while waiting (w >= 1), mode 2: flush on the accepting cycle
    task automatic do_fetch(input logic [31:0] pc, input int w, input int s,
                            input logic [31:0] d, input int mode);
        logic disc;
        logic fl;
        disc = (mode == 1);
        addr_q.push_back(pc);
        if (mode == 0) exp_q.push_back(resp_t'{instr: d, exc: 1'b0});
        drive(pc, 1'b0, 1'b0, 1'b0, $urandom);
        check1("issue_stall_request", stall_request, 1'b1);
        for (int i = 0; i < w; i++) begin
            fl = (mode == 1) && (i == 0 || $urandom_range(0, 3) == 0);
            drive(fl ? $urandom : pc, fl, 1'($urandom_range(0, 1)), 1'b0, $urandom);
            check1("wait_stall_request", stall_request, 1'b1);
            check1("wait_bus_request", bus_request, 1'b1);
            check32("wait_bus_address", bus_address, pc);
        end
        for (int i = 0; i < s; i++) begin
            fl = disc && ($urandom_range(0, 1) == 1);
            drive(pc, fl, 1'b1, 1'b1, d);
            check1("held_stall_request", stall_request, 1'b1);
            check1("held_bus_request", bus_request, 1'b1);
            check32("held_bus_address", bus_address, pc);
        end
        fl = (mode == 2) || (disc && $urandom_range(0, 1) == 1);
        drive(pc, fl, 1'b0, 1'b1, d);
        check1("accept_stall_request", stall_request, disc);
        check1("accept_bus_request", bus_request, 1'b1);
    endtask

    task automatic misaligned(input logic [31:0] pc_in);
        logic [31:0] pc;
        pc = pc_in;
        if (pc[1:0] == 2'b00) pc[0] = 1'b1;
        exp_q.push_back(resp_t'{instr: NOP, exc: 1'b1});
        drive(pc, 1'b0, 1'b0, 1'b0, $urandom);
        check1("misaligned_stall_request", stall_request, 1'b0);
        drive(pc, 1'b0, 1'b1, 1'b0, $urandom);
        check1("misaligned_no_bus_request", bus_request, 1'b0);
        check1("misaligned_valid_held", instruction_valid, 1'b1);
        check1("misaligned_exception_held", fetch_exception, 1'b1);
    endtask

    // Idle under stall_hold, then a flush cycle so every delivery shows as a fresh valid rise.
    task automatic gap_sep();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            drive($urandom, 1'b0, 1'b1, 1'b0, $urandom);
            check1("gap_bus_request", bus_request, 1'b0);
        end
        drive($urandom, 1'b1, 1'($urandom_range(0, 1)), 1'b0, $urandom);
        check1("flush_stall_request", stall_request, 1'b0);
    endtask

`ifdef INST_FETCH_TIMEOUT_EN
    task automatic timeouts();
        exp_q.push_back(resp_t'{instr: NOP, exc: 1'b1});
        drive(32'h0000_0200, 1'b0, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < TO; i++) begin
            drive(32'h0000_0200, 1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom);
            check1("timeout_bus_request_up", bus_request, 1'b1);
        end
        drive(32'h0000_0200, 1'b0, 1'b1, 1'b0, $urandom);
        check1("timeout_bus_request_dropped", bus_request, 1'b0);
        gap_sep();
        drive(32'h0000_0300, 1'b0, 1'b0, 1'b0, $urandom);
        drive(32'h0000_0400, 1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < TO; i++) begin
            drive(32'h0000_0400, 1'b0, 1'b0, 1'b0, $urandom);
            check1("discard_timeout_bus_request_up", bus_request, 1'b1);
        end
        drive(32'h0000_0400, 1'b0, 1'b1, 1'b0, $urandom);
        check1("discard_timeout_bus_request_dropped", bus_request, 1'b0);
        check1("discard_timeout_no_valid", instruction_valid, 1'b0);
    endtask
`endif

    initial begin : monitor
        logic  pv;
        resp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (bus_request && bus_ready && !stall_hold) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transfer: address %h, none expected", bus_address);
                    end else begin
                        check32("bus_address", bus_address, addr_q.pop_front());
                    end
                end
                if (instruction_valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: instruction %h, none expected", instruction);
                    end else begin
                        e = exp_q.pop_front();
                        check32("instruction", instruction, e.instr);
                        check1("fetch_exception", fetch_exception, e.exc);
                    end
                end
                pv = instruction_valid;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] pc;
        int          kind;
        reset         = 1'b1;
        pc_address    = 32'h0;
        pc_flush      = 1'b0;
        stall_hold    = 1'b1;
        bus_ready     = 1'b0;
        bus_read_data = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        check1("reset_bus_request", bus_request, 1'b0);
        check32("reset_bus_address", bus_address, 32'h0);
        check32("reset_instruction", instruction, 32'h0);
        check1("reset_instruction_valid", instruction_valid, 1'b0);
        check1("reset_fetch_exception", fetch_exception, 1'b0);
        reset = 1'b0;

        do_fetch(32'h0000_0000, 0, 0, 32'h2401_0005, 0);
        gap_sep();
        do_fetch(32'h0000_0010, 3, 0, $urandom, 0);
        gap_sep();
        do_fetch(32'h0000_0040, 2, 0, 32'hDEAD_BEEF, 1);
        do_fetch(32'h0000_0100, 0, 0, $urandom, 0);
        gap_sep();
        misaligned(32'h0000_0006);
        gap_sep();
        do_fetch(32'h0000_0020, 0, 2, $urandom, 0);
        gap_sep();
        do_fetch(32'h0000_0080, 1, 0, $urandom, 2);
        gap_sep();
`ifdef INST_FETCH_TIMEOUT_EN
        timeouts();
        gap_sep();
`endif

        for (int n = 0; n < 150; n++) begin
            pc = $urandom;
            pc[1:0] = 2'b00;
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: do_fetch(pc, $urandom_range(0, MAXW), $urandom_range(0, MAXS), $urandom, 0);
                2:    do_fetch(pc, $urandom_range(1, MAXW), $urandom_range(0, MAXS), $urandom, 1);
                3:    do_fetch(pc, $urandom_range(0, MAXW), $urandom_range(0, MAXS), $urandom, 2);
                default: misaligned($urandom);
            endcase
            gap_sep();
        end

        repeat (3) drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_deliveries: %0d outstanding, expected 0", exp_q.size());
        end
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_transfers: %0d outstanding, expected 0", addr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_port.md
Name: inst_fetch_port

Overview:
- Bus-master front end that consumes the program counter value from the IF-stage PC register.
- Issues a request/ready read on the instruction bus for that address and delivers the returned word to the IF/ID boundary.
- Raises stall_request so the stall controller freezes the PC while a fetch is outstanding.
- Discards stale responses after a PC redirect (flush).

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQUEST/DISCARD cycles before the fetch is abandoned (used only with the optional feature).
- NOP_WORD, 32'h00000000: instruction substituted on an exception.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pc_address  input  32  current PC register value
- pc_flush  input  1  redirect this cycle; in-flight result is stale
- stall_hold  input  1  downstream stalled; hold outputs, do not accept or issue
- stall_request  output  1  combinational; PC must not advance
- bus_request  output  1  registered read request
- bus_address  output  32  registered fetch address
- bus_ready  input  1  responder data valid
- bus_read_data  input  32  instruction word
- instruction  output  32  fetched word to IF/ID
- instruction_valid  output  1  instruction holds a live result
- fetch_exception  output  1  accompanies a valid NOP: misaligned PC or timeout

Behaviour:
- Reset (synchronous, active-high): state=IDLE; bus_request=0; bus_address=0; instruction=0; instruction_valid=0; fetch_exception=0; timeout counter=0.
- Reset has priority over all inputs. A mid-transaction reset drops bus_request at that edge; the responder tolerates abandoned requests.
- Handshake: a transfer completes on an edge where bus_request=1, bus_ready=1 and stall_hold=0.
  - While stall_hold=1, bus_ready is ignored. The responder holds bus_ready and bus_read_data until the transfer is accepted.
  - bus_address is stable while bus_request=1.
- States are IDLE, REQUEST and DISCARD.
- IDLE:
  - pc_flush=1: stay IDLE; instruction_valid<=0; fetch_exception<=0.
  - else stall_hold=1: hold all outputs.
  - else pc_address[1:0]!=0: instruction<=NOP_WORD; instruction_valid<=1; fetch_exception<=1; stay IDLE; no bus request.
  - else: bus_address<=pc_address; bus_request<=1; instruction_valid<=0; go to REQUEST.
- REQUEST:
  - Transfer completes and pc_flush=0: instruction<=bus_read_data; instruction_valid<=1; fetch_exception<=0; bus_request<=0; go to IDLE.
  - Transfer completes and pc_flush=1: data dropped; instruction_valid<=0; go to IDLE.
  - No transfer and pc_flush=1: go to DISCARD with bus_request still held.
- DISCARD:
  - Hold bus_request until the transfer completes.
  - Drop the data; instruction_valid stays 0; go to IDLE.
  - A further pc_flush has no extra effect.
- stall_request (combinational):
  - IDLE: pc_address[1:0]==0 and !pc_flush.
  - REQUEST: !(bus_ready and !stall_hold).
  - DISCARD: 1.
- Latency and throughput: a ready responder gives 2 cycles from PC to instruction_valid, with a peak throughput of one instruction per 2 cycles. Each extra wait cycle on bus_ready adds one cycle.
- instruction_valid and fetch_exception are registered and change only at the edges listed above. They are held unchanged while stall_hold=1, except that pc_flush clears them.

Optional Feature:
- Macro: INST_FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQUEST/DISCARD and increments on each waiting cycle.
  - When the counter equals TIMEOUT_CYCLES-1 with no transfer, bus_request<=0 and the state goes to IDLE.
  - From REQUEST: instruction<=NOP_WORD, instruction_valid<=1, fetch_exception<=1.
  - From DISCARD: nothing is delivered.
  - Counter wrap is impossible, since it is bounded by the parameter.
- Undefined: no counter logic. The block waits indefinitely for bus_ready, and fetch_exception flags only misaligned PCs.

Test Plan:
- Reset, then pc_address=0x0000_0000, bus_ready tied 1, bus_read_data=0x2401_0005 -> bus_request rises cycle 1; instruction=0x2401_0005, instruction_valid=1 at cycle 2; stall_request 1 in cycle 0, 0 in cycle 1.
- pc_address=0x0000_0010, bus_ready after 3 wait cycles -> stall_request stays 1 for 4 cycles; bus_address=0x10 stable throughout; one valid pulse with the data.
- pc_flush pulsed while waiting in REQUEST, ready 2 cycles later with 0xDEAD_BEEF -> DISCARD entered; no instruction_valid; next fetch uses the redirected pc_address=0x0000_0100.
- pc_address=0x0000_0006 -> no bus_request; instruction=0, instruction_valid=1, fetch_exception=1; stall_request=0.
- stall_hold=1 in REQUEST with bus_ready=1 -> no capture, bus_request held; after stall_hold falls, capture in 1 cycle.
- With INST_FETCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, bus_ready never rises -> bus_request drops after 4 cycles; fetch_exception=1 with instruction=0.
